store_xlat_queue: RTL and testbench

Parametrised store front-end for the LSU. It accepts stores from issue into a DEPTH-entry in-order queue, rotates store data to the address byte offset, and translates each head entry through the DTLB. It pushes translated stores into the store buffer and reports completion or exception back to issue. Unlike the single-slot store unit, several stores can be accepted while an earlier one waits on translation or on a full store buffer.

---
 rtl/store_xlat_queue_pkg.sv | 29 ++
 rtl/store_data_rotate.sv | 25 ++
 rtl/store_xlat_queue.sv | 166 ++++++++++++++++
 tb/tb_store_xlat_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_xlat_queue_pkg.sv
// Shared types for the store translation queue: entry layout, head FSM states,
// lane-offset width helper. Entry fields are sized for the widest supported configuration.
package store_xlat_pkg;

    localparam int XQ_VLEN_MAX = 64;
    localparam int XQ_PLEN_MAX = 64;
    localparam int XQ_DW_MAX   = 512;
    localparam int XQ_TID_MAX  = 8;

    typedef struct packed {
        logic [XQ_VLEN_MAX-1:0]   vaddr;
        logic [XQ_PLEN_MAX-1:0]   paddr;
        logic [XQ_DW_MAX-1:0]     data;
        logic [XQ_DW_MAX/8-1:0]   be;
        logic [1:0]               size;
        logic [XQ_TID_MAX-1:0]    trans_id;
    } xq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XLAT = 2'd1,
        PUSH = 2'd2
    } head_state_e;

    function automatic int lane_off_w(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/store_data_rotate.sv
// Byte rotator: moves LSB-justified store data up to its lane offset, wrapping
// bytes that fall off the top back into the low lanes.
module store_data_rotate #(
    parameter int DATA_WIDTH = 64,
    parameter int OFF_W      = 3
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [OFF_W-1:0]      i_off,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int NB = DATA_WIDTH / 8;

    logic [OFF_W-1:0] w_src;

    always_comb begin
        o_data = '0;
        w_src  = '0;
        for (int i = 0; i < NB; i++) begin
            // Source lane index wraps naturally in OFF_W bits.
            w_src = OFF_W'(i) - i_off;
            o_data[i*8 +: 8] = i_data[w_src*8 +: 8];
        end
    end

endmodule

// File: rtl/store_xlat_queue.sv
// In-order store queue: rotate at enqueue, translate head through the DTLB, push to the
// store buffer, registered writeback. STORE_XLAT_FWD_EN enables the page-offset alias check.
module store_xlat_queue
    import store_xlat_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int VLEN          = 64,
    parameter int PLEN          = 56,
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [VLEN-1:0]            vaddr_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic [DATA_WIDTH/8-1:0]    be_i,
    input  logic [1:0]                 size_i,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    output logic                       translation_req_o,
    output logic [VLEN-1:0]            xlat_vaddr_o,
    input  logic                       dtlb_hit_i,
    input  logic [PLEN-1:0]            paddr_i,
    input  logic                       ex_valid_i,
    output logic                       sb_valid_o,
    input  logic                       sb_ready_i,
    output logic [PLEN-1:0]            sb_paddr_o,
    output logic [DATA_WIDTH-1:0]      sb_data_o,
    output logic [DATA_WIDTH/8-1:0]    sb_be_o,
    output logic [1:0]                 sb_size_o,
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic                       wb_ex_o,
    input  logic [11:0]                page_offset_i,
    output logic                       page_offset_matches_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int LW = lane_off_w(DATA_WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    xq_entry_t               r_q [DEPTH];
    logic [PW-1:0]           r_wptr, r_rptr;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    head_state_e             r_state, w_state_nxt;
    logic                    r_wb_valid, r_wb_ex;
    logic [TRANS_ID_BITS-1:0] r_wb_id;

    xq_entry_t               w_head;
    logic                    w_nonempty, w_ready, w_push, w_capture, w_ex_pop, w_sb_pop, w_pop;
    logic [DATA_WIDTH-1:0]   w_rot_data;

    store_data_rotate #(.DATA_WIDTH(DATA_WIDTH), .OFF_W(LW)) u_rot (
        .i_data (data_i),
        .i_off  (vaddr_i[LW-1:0]),
        .o_data (w_rot_data)
    );

    assign w_head     = r_q[r_rptr];
    assign w_nonempty = (r_cnt != '0);
    assign w_ready    = (r_cnt != CW'(DEPTH));
    assign w_push     = valid_i && w_ready && !flush_i;
    assign w_capture  = (r_state == XLAT) && dtlb_hit_i && !ex_valid_i && !flush_i;
    assign w_ex_pop   = (r_state == XLAT) && dtlb_hit_i &&  ex_valid_i && !flush_i;
    assign w_sb_pop   = (r_state == PUSH) && sb_ready_i && !flush_i;
    assign w_pop      = w_ex_pop || w_sb_pop;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_push && w_pop) w_cnt_nxt = r_cnt - CW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_push) w_state_nxt = XLAT;
            XLAT: if (dtlb_hit_i) begin
                if (!ex_valid_i)           w_state_nxt = PUSH;
                else if (w_cnt_nxt != '0)  w_state_nxt = XLAT;
                else                       w_state_nxt = IDLE;
            end
            PUSH: if (sb_ready_i) w_state_nxt = (w_cnt_nxt != '0) ? XLAT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_cnt <= w_cnt_nxt;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q[r_wptr].vaddr    <= XQ_VLEN_MAX'(vaddr_i);
            r_q[r_wptr].paddr    <= '0;
            r_q[r_wptr].data     <= XQ_DW_MAX'(w_rot_data);
            r_q[r_wptr].be       <= (XQ_DW_MAX/8)'(be_i);
            r_q[r_wptr].size     <= size_i;
            r_q[r_wptr].trans_id <= XQ_TID_MAX'(trans_id_i);
        end
        if (w_capture) r_q[r_rptr].paddr <= XQ_PLEN_MAX'(paddr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_valid <= 1'b0;
            r_wb_ex    <= 1'b0;
            r_wb_id    <= '0;
        end else begin
            r_wb_valid <= w_pop;
            r_wb_ex    <= w_ex_pop;
            if (w_pop) r_wb_id <= TRANS_ID_BITS'(w_head.trans_id);
        end
    end

    assign ready_o           = w_ready;
    assign count_o           = r_cnt;
    assign translation_req_o = (r_state == XLAT) && !flush_i;
    assign sb_valid_o        = (r_state == PUSH) && !flush_i;
    assign xlat_vaddr_o      = w_nonempty ? VLEN'(w_head.vaddr)         : '0;
    assign sb_paddr_o        = w_nonempty ? PLEN'(w_head.paddr)         : '0;
    assign sb_data_o         = w_nonempty ? DATA_WIDTH'(w_head.data)    : '0;
    assign sb_be_o           = w_nonempty ? (DATA_WIDTH/8)'(w_head.be)  : '0;
    assign sb_size_o         = w_nonempty ? w_head.size                 : '0;
    assign wb_valid_o        = r_wb_valid;
    assign wb_trans_id_o     = r_wb_id;
    assign wb_ex_o           = r_wb_ex;

    logic w_unused_po;
    assign w_unused_po = ^page_offset_i;

`ifdef STORE_XLAT_FWD_EN
    logic [PW-1:0] w_rel;

    always_comb begin
        w_rel = '0;
        page_offset_matches_o = valid_i && (vaddr_i[11:LW] == page_offset_i[11:LW]);
        for (int i = 0; i < DEPTH; i++) begin
            // Entry i is live when its distance from the head is below the count.
            w_rel = PW'(i) - r_rptr;
            if ((CW'(w_rel) < r_cnt) && (r_q[i].vaddr[11:LW] == page_offset_i[11:LW]))
                page_offset_matches_o = 1'b1;
        end
    end
`else
    assign page_offset_matches_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_xlat_queue.sv
// Directed bench for store_xlat_queue with a push/writeback scoreboard and a behavioural DTLB.
module tb_store_xlat_queue;
    localparam int DW = 64, VL = 64, PL = 56, D = 4, TB = 3;
    localparam logic [63:0] PX = 64'h00A5_0000_0000;

    logic           clk_i = 1'b0;
    logic           rst_i, flush_i, valid_i, ready_o;
    logic [VL-1:0]  vaddr_i;
    logic [DW-1:0]  data_i;
    logic [7:0]     be_i;
    logic [1:0]     size_i;
    logic [TB-1:0]  trans_id_i;
    logic           translation_req_o, dtlb_hit_i, ex_valid_i;
    logic [VL-1:0]  xlat_vaddr_o;
    logic [PL-1:0]  paddr_i, sb_paddr_o;
    logic           sb_valid_o, sb_ready_i;
    logic [DW-1:0]  sb_data_o;
    logic [7:0]     sb_be_o;
    logic [1:0]     sb_size_o;
    logic           wb_valid_o, wb_ex_o;
    logic [TB-1:0]  wb_trans_id_o;
    logic [11:0]    page_offset_i;
    logic           page_offset_matches_o;
    logic [2:0]     count_o;
    logic           tlb_on;

    always #5 clk_i = ~clk_i;

    // DTLB model: hits when enabled, faults on vaddr[15:12]==E, fixed paddr transform.
    assign dtlb_hit_i = tlb_on && translation_req_o;
    assign ex_valid_i = dtlb_hit_i && (xlat_vaddr_o[15:12] == 4'hE);
    assign paddr_i    = PL'(xlat_vaddr_o ^ PX);

    store_xlat_queue #(.DATA_WIDTH(DW), .VLEN(VL), .PLEN(PL), .DEPTH(D), .TRANS_ID_BITS(TB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .vaddr_i(vaddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i), .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .xlat_vaddr_o(xlat_vaddr_o),
        .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .ex_valid_i(ex_valid_i),
        .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i), .sb_paddr_o(sb_paddr_o),
        .sb_data_o(sb_data_o), .sb_be_o(sb_be_o), .sb_size_o(sb_size_o),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_ex_o(wb_ex_o),
        .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
        .count_o(count_o)
    );

    typedef struct packed {
        logic [PL-1:0] paddr;
        logic [DW-1:0] data;
        logic [7:0]    be;
        logic [1:0]    size;
    } sb_exp_t;
    typedef struct packed {
        logic          ex;
        logic [TB-1:0] id;
    } wb_exp_t;

    sb_exp_t sbq[$];
    wb_exp_t wbq[$];
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] d, input logic [63:0] va);
        logic [63:0] r;
        int off;
        r = '0;
        off = int'(va[2:0]);
        for (int i = 0; i < 8; i++) r[((i + off) % 8)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input logic [63:0] va, input logic [63:0] d, input logic [7:0] be,
                       input logic [1:0] sz, input logic [TB-1:0] id, input bit exp);
        sb_exp_t s;
        wb_exp_t w;
        valid_i = 1'b1; vaddr_i = va; data_i = d; be_i = be; size_i = sz; trans_id_i = id;
        if (exp) begin
            if (va[15:12] != 4'hE) begin
                s.paddr = PL'(va ^ PX); s.data = rot(d, va); s.be = be; s.size = sz;
                sbq.push_back(s);
            end
            w.ex = (va[15:12] == 4'hE); w.id = id;
            wbq.push_back(w);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (count_o == 0) break;
            tick();
        end
        chk({tag, "_count"}, count_o, 0);
        repeat (3) tick();
        chk({tag, "_sbq_left"}, sbq.size(), 0);
        chk({tag, "_wbq_left"}, wbq.size(), 0);
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        sb_exp_t se;
        wb_exp_t we;
        if (!rst_i) begin
            if (sb_valid_o && sb_ready_i) begin
                if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    se = sbq.pop_front();
                    chk("sb_paddr", sb_paddr_o, se.paddr);
                    chk("sb_data", sb_data_o, se.data);
                    chk("sb_be", sb_be_o, se.be);
                    chk("sb_size", sb_size_o, se.size);
                end
            end
            if (wb_valid_o) begin
                if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
                else begin
                    we = wbq.pop_front();
                    chk("wb_id", wb_trans_id_o, we.id);
                    chk("wb_ex", wb_ex_o, we.ex);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_d;
        int n;
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; vaddr_i = '0; data_i = '0; be_i = '0;
        size_i = '0; trans_id_i = '0; sb_ready_i = 1'b0; page_offset_i = '0; tlb_on = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;

        chk("rst_ready", ready_o, 1);
        chk("rst_treq", translation_req_o, 0);
        chk("rst_sbv", sb_valid_o, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_wbex", wb_ex_o, 0);
        chk("rst_wbid", wb_trans_id_o, 0);
        chk("rst_match", page_offset_matches_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_xvaddr", xlat_vaddr_o, 0);
        chk("rst_sbdata", sb_data_o, 0);

        // Minimum latency path
        tlb_on = 1'b1; sb_ready_i = 1'b1;
        enq(64'h1003, 64'hAABBCCDD, 8'h78, 2'd2, 3'd5, 1'b1);
        chk("lat_treq", translation_req_o, 1);
        chk("lat_count", count_o, 1);
        tick();
        chk("lat_sbv", sb_valid_o, 1);
        chk("lat_data", sb_data_o, 64'h00AA_BBCC_DD00_0000);
        chk("lat_be", sb_be_o, 8'h78);
        tick();
        chk("lat_wbv", wb_valid_o, 1);
        chk("lat_wbid", wb_trans_id_o, 3'd5);
        chk("lat_wbex", wb_ex_o, 0);
        drain("lat");

        // Back-to-back: two stores drain in two cycles each
        enq(64'h1100, 64'h0102, 8'h03, 2'd1, 3'd6, 1'b1);
        enq(64'h1106, 64'hBEEF, 8'hC0, 2'd1, 3'd7, 1'b1);
        n = 0;
        while (count_o != 0 && n < 20) begin tick(); n++; end
        chk("thru_cycles", n, 3);
        drain("thru");

        // Fill with TLB stalled
        tlb_on = 1'b0;
        enq(64'h1000, 64'h1111_2222_3333_4444, 8'hFF, 2'd3, 3'd0, 1'b1);
        enq(64'h1001, 64'h0000_0000_0000_ABCD, 8'h06, 2'd1, 3'd1, 1'b1);
        enq(64'h1005, 64'h0000_0000_1234_5678, 8'hE0, 2'd2, 3'd2, 1'b1);
        enq(64'h1007, 64'h0000_0000_0000_00EE, 8'h80, 2'd0, 3'd3, 1'b1);
        chk("full_ready", ready_o, 0);
        chk("full_count", count_o, 4);
        chk("full_treq", translation_req_o, 1);
        chk("full_head", xlat_vaddr_o, 64'h1000);
        valid_i = 1'b1; vaddr_i = 64'h9000; trans_id_i = 3'd7;
        tick();
        valid_i = 1'b0;
        chk("full_drop", count_o, 4);
        tlb_on = 1'b1;
        drain("full");

        // Exception on head, next entry proceeds
        enq(64'hE010, 64'h55, 8'h01, 2'd0, 3'd4, 1'b1);
        enq(64'h3008, 64'h77, 8'h01, 2'd0, 3'd5, 1'b1);
        drain("exc");

        // Store-buffer backpressure
        sb_ready_i = 1'b0;
        enq(64'h4002, 64'h1122_3344_5566_7788, 8'hFF, 2'd3, 3'd6, 1'b1);
        exp_d = rot(64'h1122_3344_5566_7788, 64'h4002);
        for (int k = 0; k < 10; k++) begin
            if (sb_valid_o) break;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_sbv", sb_valid_o, 1);
            chk("bp_data", sb_data_o, exp_d);
            chk("bp_paddr", sb_paddr_o, PL'(64'h4002 ^ PX));
            chk("bp_wbv", wb_valid_o, 0);
            tick();
        end
        sb_ready_i = 1'b1;
        tick();
        chk("bp_wb_after", wb_valid_o, 1);
        drain("bp");

        // Flush with head in PUSH
        sb_ready_i = 1'b0;
        enq(64'h5000, 64'h1, 8'h01, 2'd0, 3'd1, 1'b0);
        enq(64'h5001, 64'h2, 8'h02, 2'd0, 3'd2, 1'b0);
        enq(64'h5002, 64'h3, 8'h04, 2'd0, 3'd3, 1'b0);
        chk("fl_pre_sbv", sb_valid_o, 1);
        chk("fl_pre_count", count_o, 3);
        flush_i = 1'b1; sb_ready_i = 1'b1; valid_i = 1'b1; vaddr_i = 64'h6000;
        #1;
        chk("fl_sbv_gated", sb_valid_o, 0);
        chk("fl_treq_gated", translation_req_o, 0);
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("fl_count", count_o, 0);
        chk("fl_ready", ready_o, 1);
        for (int k = 0; k < 4; k++) begin
            chk("fl_no_wb", wb_valid_o, 0);
            tick();
        end

        // Page-offset alias check
        tlb_on = 1'b0; sb_ready_i = 1'b0;
        enq(64'h2F08, 64'h9, 8'h01, 2'd0, 3'd2, 1'b0);
        page_offset_i = 12'hF0C;
        #1;
`ifdef STORE_XLAT_FWD_EN
        chk("fwd_hit", page_offset_matches_o, 1);
`else
        chk("fwd_off_tied", page_offset_matches_o, 0);
`endif
        page_offset_i = 12'hF10;
        #1;
        chk("fwd_miss", page_offset_matches_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fwd_flushed", count_o, 0);

        // Reset mid-operation
        enq(64'h7000, 64'h5, 8'h01, 2'd0, 3'd1, 1'b0);
        chk("mr_count_pre", count_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mr_count", count_o, 0);
        chk("mr_treq", translation_req_o, 0);
        chk("mr_wbv", wb_valid_o, 0);
        chk("mr_xvaddr", xlat_vaddr_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
